// File: rtl/sdram_write_if.sv
// rtl/sdram_write_if.sv - request, FIFO handshake, command bus and DQ signals of the SDRAM burst-write engine
`timescale 1ns/1ps

interface sdram_write_if;
    logic        init_end;
    logic        wr_en;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic [9:0]  wr_burst_len;
    logic        wr_ack;
    logic        wr_end;
    logic [3:0]  write_cmd;
    logic [1:0]  write_ba;
    logic [12:0] write_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;

    modport master (
        output init_end, wr_en, wr_addr, wr_data, wr_burst_len,
        input  wr_ack, wr_end, write_cmd, write_ba, write_addr, wr_sdram_en, wr_sdram_data
    );

    modport slave (
        input  init_end, wr_en, wr_addr, wr_data, wr_burst_len,
        output wr_ack, wr_end, write_cmd, write_ba, write_addr, wr_sdram_en, wr_sdram_data
    );
endinterface

// File: rtl/sdram_write.sv
// rtl/sdram_write.sv - full-page burst-write engine: ACTIVE, WRITE, data stream, BURST STOP, PRECHARGE
`timescale 1ns/1ps

module sdram_write #(
    parameter int TRCD_CLK  = 2,
    parameter int TRP_CLK   = 2,
    parameter int MAX_BURST = 512
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    sdram_write_if.slave  bus
);

    localparam logic [3:0] CMD_NOP    = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE = 4'b0011;
    localparam logic [3:0] CMD_WRITE  = 4'b0100;
    localparam logic [3:0] CMD_BSTOP  = 4'b0110;
    localparam logic [3:0] CMD_PRE    = 4'b0010;

    localparam logic [9:0] TRCD_LAST = 10'((TRCD_CLK > 0) ? TRCD_CLK - 1 : 0);
    localparam logic [9:0] TRP_LAST  = 10'((TRP_CLK > 0) ? TRP_CLK - 1 : 0);
    localparam logic [9:0] MAX_LEN   = 10'(MAX_BURST);

    typedef enum logic [3:0] {
        WR_IDLE, WR_ACTIVE, WR_TRCD, WR_WRITE, WR_DATA,
        WR_BSTOP, WR_PRE, WR_TRP, WR_END
    } state_t;

    state_t      state, state_nxt;
    logic [9:0]  cnt, cnt_nxt;
    logic [9:0]  burst_len, len_eff;
    logic [1:0]  bank_lat;
    logic [8:0]  col_lat;
    logic        accept;

    logic [3:0]  cmd_nxt;
    logic [1:0]  ba_nxt;
    logic [12:0] addr_nxt;
    logic        en_nxt;
    logic [15:0] data_nxt;
    logic        ack_nxt;
    logic        end_nxt;

    assign accept = (state == WR_IDLE) && bus.wr_en && bus.init_end;

    always_comb begin
        len_eff = bus.wr_burst_len;
        if (bus.wr_burst_len == 10'd0)
            len_eff = 10'd1;
        else if (bus.wr_burst_len > MAX_LEN)
            len_eff = MAX_LEN;
    end

    // cnt restarts at zero on every state change and counts the cycles spent in the current state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            WR_IDLE:   if (accept) state_nxt = WR_ACTIVE;
            WR_ACTIVE: state_nxt = (TRCD_CLK == 0) ? WR_WRITE : WR_TRCD;
            WR_TRCD:   if (cnt == TRCD_LAST) state_nxt = WR_WRITE;
                       else cnt_nxt = cnt + 10'd1;
            WR_WRITE:  state_nxt = (burst_len == 10'd1) ? WR_BSTOP : WR_DATA;
            WR_DATA:   if (cnt == burst_len - 10'd2) state_nxt = WR_BSTOP;
                       else cnt_nxt = cnt + 10'd1;
            WR_BSTOP:  state_nxt = WR_PRE;
            WR_PRE:    state_nxt = (TRP_CLK == 0) ? WR_END : WR_TRP;
            WR_TRP:    if (cnt == TRP_LAST) state_nxt = WR_END;
                       else cnt_nxt = cnt + 10'd1;
            WR_END:    state_nxt = WR_IDLE;
            default:   state_nxt = WR_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so every bus pin comes straight from a flop
    always_comb begin
        cmd_nxt  = CMD_NOP;
        ba_nxt   = 2'b11;
        addr_nxt = 13'h1fff;
        en_nxt   = 1'b0;
        data_nxt = 16'h0000;
        end_nxt  = 1'b0;
        case (state_nxt)
            WR_ACTIVE: begin
                cmd_nxt  = CMD_ACTIVE;
                ba_nxt   = bus.wr_addr[23:22];
                addr_nxt = bus.wr_addr[21:9];
            end
            WR_WRITE: begin
                cmd_nxt  = CMD_WRITE;
                ba_nxt   = bank_lat;
                addr_nxt = {4'b0000, col_lat};
                en_nxt   = 1'b1;
                data_nxt = bus.wr_data;
            end
            WR_DATA: begin
                en_nxt   = 1'b1;
                data_nxt = bus.wr_data;
            end
            WR_BSTOP:  cmd_nxt = CMD_BSTOP;
            WR_PRE: begin
                cmd_nxt  = CMD_PRE;
                ba_nxt   = bank_lat;
                addr_nxt = 13'h0400;
            end
            WR_END:    end_nxt = 1'b1;
            default:   cmd_nxt = CMD_NOP;
        endcase
    end

    // FIFO is show-ahead: request one cycle before each word is captured onto DQ
    always_comb begin
        ack_nxt = 1'b0;
        if (state_nxt == WR_ACTIVE && TRCD_CLK == 0)
            ack_nxt = 1'b1;
        else if (state_nxt == WR_TRCD && cnt_nxt == TRCD_LAST)
            ack_nxt = 1'b1;
        else if (state_nxt == WR_WRITE && burst_len > 10'd1)
            ack_nxt = 1'b1;
        else if (state_nxt == WR_DATA && (cnt_nxt + 10'd2) < burst_len)
            ack_nxt = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state             <= WR_IDLE;
            cnt               <= '0;
            burst_len         <= '0;
            bank_lat          <= '0;
            col_lat           <= '0;
            bus.write_cmd     <= CMD_NOP;
            bus.write_ba      <= 2'b11;
            bus.write_addr    <= 13'h1fff;
            bus.wr_sdram_en   <= 1'b0;
            bus.wr_sdram_data <= 16'h0000;
            bus.wr_ack        <= 1'b0;
            bus.wr_end        <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            if (accept) begin
                burst_len <= len_eff;
                bank_lat  <= bus.wr_addr[23:22];
                col_lat   <= bus.wr_addr[8:0];
            end
            bus.write_cmd     <= cmd_nxt;
            bus.write_ba      <= ba_nxt;
            bus.write_addr    <= addr_nxt;
            bus.wr_sdram_en   <= en_nxt;
            bus.wr_sdram_data <= data_nxt;
            bus.wr_ack        <= ack_nxt;
            bus.wr_end        <= end_nxt;
        end
    end

endmodule
